// File: rtl/printer_spooler_if.sv
// Bus and printer-side signals of the print spooler.
//   address/mio/readRequest/busValid : CPU I/O bus access qualifiers
//   printerData/printerStrobe        : byte and strobe toward the printer
//   printerAck                       : printer acknowledge (level)
// The bidirectional data bus stays a plain inout port on the spooler.
interface printer_spooler_if #(
   parameter int unsigned ADDRESS_WIDTH = 16
);
   logic [ADDRESS_WIDTH-1:0] address;
   logic                     mio;
   logic                     readRequest;
   logic                     busValid;
   logic [7:0]               printerData;
   logic                     printerStrobe;
   logic                     printerAck;

   // Spooler side
   modport slave (
      input  address, mio, readRequest, busValid, printerAck,
      output printerData, printerStrobe
   );

   // CPU / printer side
   modport master (
      output address, mio, readRequest, busValid, printerAck,
      input  printerData, printerStrobe
   );
endinterface

// File: rtl/printer_spooler.sv
// Memory-mapped print spooler: CPU byte writes to DATA_ADDR are queued in a
// FIFO and drained to the printer by a strobe/ack FSM; CPU reads of STAT_ADDR
// return {count[3:0], timeoutErr, overflow, busy, full}.
//   clock : system clock
//   reset : asynchronous active-low reset
//   bus   : bus qualifiers in, printer data/strobe out, printer ack in
//   data  : bidirectional CPU data bus, driven only during a status read
module printer_spooler #(
   parameter int unsigned              ADDRESS_WIDTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDR     = 16'h2000,
   parameter logic [ADDRESS_WIDTH-1:0] STAT_ADDR     = 16'h2001,
   parameter int unsigned              FIFO_DEPTH    = 8,
   parameter int unsigned              STROBE_CYCLES = 2,
   parameter int unsigned              ACK_TIMEOUT   = 64
) (
   input  logic              clock,
   input  logic              reset,
   printer_spooler_if.slave  bus,
   inout  wire  [7:0]        data
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned TMR_MAX = (ACK_TIMEOUT > STROBE_CYCLES) ? ACK_TIMEOUT : STROBE_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_WAIT_ACK,
      S_RELEASE
   } state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [7:0]       pdata_q, pdata_d;
   logic             strobe_q, strobe_d;
   logic             overflow_q, overflow_d;
   logic             timeout_q, timeout_d;

   logic [CNT_W-1:0] count_c;
   logic [4:0]       count5_c;
   logic [3:0]       count_sat_c;
   logic             full_c, empty_c, busy_c;
   logic             wr_hit_c, stat_rd_c, push_c, pop_c, to_set_c;
   logic [7:0]       status_c;

   // Bus decode: only I/O-space accesses to the two registers do anything
   assign wr_hit_c  = bus.busValid & ~bus.mio & ~bus.readRequest & (bus.address == DATA_ADDR);
   assign stat_rd_c = bus.busValid & ~bus.mio &  bus.readRequest & (bus.address == STAT_ADDR);

   // Occupancy from pointers carrying one extra wrap bit
   assign count_c     = wr_ptr_q - rd_ptr_q;
   assign full_c      = (count_c == CNT_W'(FIFO_DEPTH));
   assign empty_c     = (count_c == '0);
   assign busy_c      = (state_q != S_IDLE);
   assign count5_c    = 5'(count_c);
   assign count_sat_c = (count5_c > 5'd15) ? 4'hF : count5_c[3:0];

   assign status_c = {count_sat_c, timeout_q, overflow_q, busy_c, full_c};
   assign data     = stat_rd_c ? status_c : 8'hzz;

   assign bus.printerData   = pdata_q;
   assign bus.printerStrobe = strobe_q;

   // Output FSM: pop, data setup, strobe, wait for ack (with timeout), release
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      pdata_d  = pdata_q;
      pop_c    = 1'b0;
      to_set_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               pdata_d = mem_q[rd_ptr_q[PTR_W-1:0]];
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            tmr_d   = '0;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (tmr_q == TMR_W'(STROBE_CYCLES - 1)) begin
               tmr_d   = '0;
               state_d = S_WAIT_ACK;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_WAIT_ACK: begin
            if (bus.printerAck) begin
               state_d = S_RELEASE;
            end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
               // byte is abandoned; the next one is fetched from IDLE
               to_set_c = 1'b1;
               state_d  = S_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_RELEASE: begin
            if (!bus.printerAck) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      strobe_d = (state_d == S_STROBE);
   end

   // FIFO and sticky status flags; full is sampled before this cycle's pop
   always_comb begin
      mem_d = mem_q;
      push_c = wr_hit_c & ~full_c;
      if (push_c) mem_d[wr_ptr_q[PTR_W-1:0]] = data;
      wr_ptr_d   = push_c ? (wr_ptr_q + CNT_W'(1)) : wr_ptr_q;
      rd_ptr_d   = pop_c  ? (rd_ptr_q + CNT_W'(1)) : rd_ptr_q;
      // a set event in the same cycle as a status read wins over the clear
      overflow_d = (overflow_q & ~stat_rd_c) | (wr_hit_c & full_c);
      timeout_d  = (timeout_q  & ~stat_rd_c) | to_set_c;
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pdata_q    <= 8'h00;
         strobe_q   <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pdata_q    <= pdata_d;
         strobe_q   <= strobe_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         mem_q      <= mem_d;
      end
   end

endmodule

// File: tb/tb_printer_spooler.sv
// Directed self-checking bench for printer_spooler.
module tb_printer_spooler;

   localparam logic [15:0] DATA_A = 16'h2000;
   localparam logic [15:0] STAT_A = 16'h2001;

   logic       clock;
   logic       reset;
   logic       tb_drv;
   logic [7:0] tb_wdata;
   wire  [7:0] data;

   int checks = 0;
   int errors = 0;

   printer_spooler_if #(.ADDRESS_WIDTH(16)) bus_if ();

   // CPU side of the shared data bus; an undriven bus floats high
   assign data = tb_drv ? tb_wdata : 8'hzz;
   pullup (data);

   printer_spooler #(
      .ADDRESS_WIDTH(16),
      .DATA_ADDR    (16'h2000),
      .STAT_ADDR    (16'h2001),
      .FIFO_DEPTH   (8),
      .STROBE_CYCLES(2),
      .ACK_TIMEOUT  (64)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if),
      .data (data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      bus_if.printerAck = 1'b0;
      bus_if.busValid = 1'b0;
      tb_drv = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic m, input logic [7:0] d);
      @(negedge clock);
      bus_if.address = a; bus_if.mio = m; bus_if.readRequest = 1'b0; bus_if.busValid = 1'b1;
      tb_wdata = d; tb_drv = 1'b1;
      @(posedge clock); #1;
      bus_if.busValid = 1'b0; tb_drv = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic m, output logic [7:0] v);
      @(negedge clock);
      bus_if.address = a; bus_if.mio = m; bus_if.readRequest = 1'b1; bus_if.busValid = 1'b1;
      #1 v = data;
      @(posedge clock); #1;
      bus_if.busValid = 1'b0; bus_if.readRequest = 1'b0;
   endtask

   // Waits for a strobe, measures its width, then acks after ack_delay cycles
   task automatic serve_byte(input int ack_delay, output logic [7:0] d, output int width,
                             output bit seen);
      seen = 1'b0; d = 8'h00; width = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus_if.printerStrobe) begin seen = 1'b1; break; end
         @(posedge clock); #1;
      end
      if (seen) begin
         d = bus_if.printerData;
         while (bus_if.printerStrobe && width < 50) begin
            width++;
            @(posedge clock); #1;
         end
         repeat (ack_delay) @(posedge clock);
         #1 bus_if.printerAck = 1'b1;
         repeat (2) @(posedge clock);
         #1 bus_if.printerAck = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b0;
      #3;
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL reset_strobe got=%b exp=0", bus_if.printerStrobe); end
      checks++; if (bus_if.printerData !== 8'h00) begin errors++;
         $display("FAIL reset_pdata got=%h exp=00", bus_if.printerData); end
      checks++; if (data !== 8'hFF) begin errors++;
         $display("FAIL reset_bus_released got=%h exp=FF(pulled)", data); end
      @(negedge clock); reset = 1'b1;
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h00) begin errors++;
         $display("FAIL reset_status got=%h exp=00", v); end
   endtask

   task automatic test_latency();
      do_reset();
      bus_write(DATA_A, 1'b0, 8'h3C);
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL lat_idle_strobe got=%b exp=0", bus_if.printerStrobe); end
      @(posedge clock); #1;
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL lat_setup_strobe got=%b exp=0", bus_if.printerStrobe); end
      checks++; if (bus_if.printerData !== 8'h3C) begin errors++;
         $display("FAIL lat_setup_pdata got=%h exp=3C", bus_if.printerData); end
      @(posedge clock); #1;
      checks++; if (bus_if.printerStrobe !== 1'b1) begin errors++;
         $display("FAIL lat_strobe_rise got=%b exp=1", bus_if.printerStrobe); end
   endtask

   task automatic test_hi();
      logic [7:0] v, d;
      int w;
      bit seen;
      do_reset();
      bus_write(DATA_A, 1'b0, 8'h48);
      bus_write(DATA_A, 1'b0, 8'h69);
      // 'H' already popped into SETUP, 'i' still queued
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h12) begin errors++;
         $display("FAIL hi_status_busy got=%h exp=12", v); end
      serve_byte(2, d, w, seen);
      checks++; if (!seen || d !== 8'h48) begin errors++;
         $display("FAIL hi_first_byte got=%h seen=%b exp=48", d, seen); end
      checks++; if (w != 2) begin errors++;
         $display("FAIL hi_first_width got=%0d exp=2", w); end
      serve_byte(2, d, w, seen);
      checks++; if (!seen || d !== 8'h69) begin errors++;
         $display("FAIL hi_second_byte got=%h seen=%b exp=69", d, seen); end
      checks++; if (w != 2) begin errors++;
         $display("FAIL hi_second_width got=%0d exp=2", w); end
      repeat (2) @(posedge clock);
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h00) begin errors++;
         $display("FAIL hi_status_drained got=%h exp=00", v); end
   endtask

   task automatic test_overflow();
      logic [7:0] v, d;
      int w;
      bit seen;
      do_reset();
      // A0 goes to the printer, A1..A8 fill the FIFO, A9 is dropped
      for (int i = 0; i < 10; i++) bus_write(DATA_A, 1'b0, 8'hA0 + 8'(i));
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h87) begin errors++;
         $display("FAIL ovf_status_full got=%h exp=87", v); end
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h83) begin errors++;
         $display("FAIL ovf_status_cleared got=%h exp=83", v); end
      checks++; if (bus_if.printerData !== 8'hA0) begin errors++;
         $display("FAIL ovf_inflight_pdata got=%h exp=A0", bus_if.printerData); end
      #1 bus_if.printerAck = 1'b1;
      repeat (2) @(posedge clock);
      #1 bus_if.printerAck = 1'b0;
      serve_byte(0, d, w, seen);
      checks++; if (!seen || d !== 8'hA1) begin errors++;
         $display("FAIL ovf_order_1 got=%h seen=%b exp=A1", d, seen); end
      serve_byte(1, d, w, seen);
      checks++; if (!seen || d !== 8'hA2) begin errors++;
         $display("FAIL ovf_order_2 got=%h seen=%b exp=A2", d, seen); end
   endtask

   task automatic test_timeout();
      logic [7:0] v, d;
      int w;
      bit seen;
      int n;
      do_reset();
      bus_write(DATA_A, 1'b0, 8'h41);
      bus_write(DATA_A, 1'b0, 8'h42);
      n = 0;
      while (!bus_if.printerStrobe && n < 20) begin @(posedge clock); #1; n++; end
      while (bus_if.printerStrobe && n < 40) begin @(posedge clock); #1; n++; end
      checks++; if (n >= 40 || bus_if.printerData !== 8'h41) begin errors++;
         $display("FAIL to_first_strobe got=%h n=%0d exp=41", bus_if.printerData, n); end
      // first WAIT_ACK cycle just sampled; the read lands on the 64th
      repeat (63) @(posedge clock);
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h12) begin errors++;
         $display("FAIL to_last_wait_cycle got=%h exp=12", v); end
      // timeout set in the read cycle survives the clear
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h18) begin errors++;
         $display("FAIL to_flag_set got=%h exp=18", v); end
      serve_byte(0, d, w, seen);
      checks++; if (!seen || d !== 8'h42) begin errors++;
         $display("FAIL to_next_byte got=%h seen=%b exp=42", d, seen); end
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v[3] !== 1'b0) begin errors++;
         $display("FAIL to_flag_cleared got=%b exp=0", v[3]); end
   endtask

   task automatic test_push_full_pop();
      logic [7:0] v;
      do_reset();
      bus_if.printerAck = 1'b1;
      // B0 parks in RELEASE while ack stays high; B1..B8 fill the FIFO
      for (int i = 0; i < 9; i++) bus_write(DATA_A, 1'b0, 8'hB0 + 8'(i));
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h83) begin errors++;
         $display("FAIL pf_full got=%h exp=83", v); end
      bus_if.printerAck = 1'b0;
      @(posedge clock);
      // FSM is IDLE with a full FIFO: this push meets the pop and loses
      bus_write(DATA_A, 1'b0, 8'hEE);
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h76) begin errors++;
         $display("FAIL pf_status got=%h exp=76", v); end
      checks++; if (bus_if.printerData !== 8'hB1) begin errors++;
         $display("FAIL pf_popped got=%h exp=B1", bus_if.printerData); end
   endtask

   task automatic test_ignored();
      logic [7:0] v;
      do_reset();
      bus_write(DATA_A, 1'b1, 8'h55);
      bus_write(16'h2002, 1'b0, 8'h66);
      bus_read(DATA_A, 1'b0, v);
      checks++; if (v !== 8'hFF) begin errors++;
         $display("FAIL ign_read_data_addr got=%h exp=FF(pulled)", v); end
      bus_read(STAT_A, 1'b1, v);
      checks++; if (v !== 8'hFF) begin errors++;
         $display("FAIL ign_read_mem_space got=%h exp=FF(pulled)", v); end
      repeat (4) @(posedge clock); #1;
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL ign_no_strobe got=%b exp=0", bus_if.printerStrobe); end
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h00) begin errors++;
         $display("FAIL ign_status got=%h exp=00", v); end
   endtask

   task automatic test_midreset();
      logic [7:0] v;
      do_reset();
      bus_write(DATA_A, 1'b0, 8'hC1);
      bus_write(DATA_A, 1'b0, 8'hC2);
      bus_write(DATA_A, 1'b0, 8'hC3);
      checks++; if (bus_if.printerStrobe !== 1'b1) begin errors++;
         $display("FAIL mr_strobe_before got=%b exp=1", bus_if.printerStrobe); end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL mr_strobe_async got=%b exp=0", bus_if.printerStrobe); end
      checks++; if (bus_if.printerData !== 8'h00) begin errors++;
         $display("FAIL mr_pdata got=%h exp=00", bus_if.printerData); end
      @(negedge clock); reset = 1'b1;
      bus_read(STAT_A, 1'b0, v);
      checks++; if (v !== 8'h00) begin errors++;
         $display("FAIL mr_status got=%h exp=00", v); end
      repeat (4) @(posedge clock); #1;
      checks++; if (bus_if.printerStrobe !== 1'b0) begin errors++;
         $display("FAIL mr_no_restrobe got=%b exp=0", bus_if.printerStrobe); end
   endtask

   initial begin
      reset = 1'b0;
      tb_drv = 1'b0;
      tb_wdata = 8'h00;
      bus_if.address = 16'h0000;
      bus_if.mio = 1'b0;
      bus_if.readRequest = 1'b0;
      bus_if.busValid = 1'b0;
      bus_if.printerAck = 1'b0;
      test_reset();
      test_latency();
      test_hi();
      test_overflow();
      test_timeout();
      test_push_full_pop();
      test_ignored();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
